// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry, 3-bit VGA colour constants and the redraw
// scheduler state encoding, shared by the keyboard display blocks.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    FILL
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin priority select.
//   req        - request vector, one bit per requester
//   last_grant - index granted most recently; search starts one above it
//   grant      - index of the first set request at or after last_grant+1,
//                wrapping modulo NUM_KEYS
//   vld        - high when any request is set (grant is 0 otherwise)
module rr_picker #(
  parameter int NUM_KEYS = 8,
  parameter int IDX_W    = 3
) (
  input  logic [NUM_KEYS-1:0] req,
  input  logic [IDX_W-1:0]    last_grant,
  output logic [IDX_W-1:0]    grant,
  output logic                vld
);

  int cand;

  always_comb begin
    grant = '0;
    vld   = 1'b0;
    cand  = 0;
    // Offsets 1..NUM_KEYS visit every index once, last_grant itself last.
    for (int i = 1; i <= NUM_KEYS; i++) begin
      cand = (int'(last_grant) + i) % NUM_KEYS;
      if (!vld && req[IDX_W'(cand)]) begin
        vld   = 1'b1;
        grant = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/key_redraw_scheduler.sv
// key_redraw_scheduler: owns the single VGA pixel-write port of the piano
// keyboard display. Every key whose pressed state changes is queued for a
// redraw; pending keys are served round-robin and each key rectangle is
// filled one pixel per clock in raster order.
//   CLOCK_50  - system clock
//   reset     - synchronous, active-high
//   key_state - level pressed state per key (1 = pressed)
//   x_out     - registered pixel x
//   y_out     - registered pixel y
//   VGA_COLOR - registered pixel colour
//   plot      - write strobe; x_out/y_out/VGA_COLOR valid while high
//   busy      - high while granting or filling
//   init_done - sticky flag: every key drawn at least once since reset
module key_redraw_scheduler
  import vga_pkg::*;
#(
  parameter int         NUM_KEYS     = 8,
  parameter int         KEY_W        = 16,
  parameter int         KEY_H        = 25,
  parameter int         X0           = 16,
  parameter int         Y0           = 89,
  parameter logic [2:0] COL_PRESSED  = COL_RED,
  parameter logic [2:0] COL_RELEASED = COL_WHITE,
  parameter logic [2:0] COL_BORDER   = COL_BLACK
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_state,
  output logic [7:0]          x_out,
  output logic [6:0]          y_out,
  output logic [2:0]          VGA_COLOR,
  output logic                plot,
  output logic                busy,
  output logic                init_done
);

  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int PX_W  = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int PY_W  = (KEY_H > 1) ? $clog2(KEY_H) : 1;

  localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(KEY_W - 1);
  localparam logic [PY_W-1:0]  PY_LAST  = PY_W'(KEY_H - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_KEYS - 1);

  if (X0 + NUM_KEYS * KEY_W > SCREEN_W) begin : g_bad_width
    $error("key_redraw_scheduler: key row runs past the right screen edge");
  end
  if (Y0 + KEY_H > SCREEN_H) begin : g_bad_height
    $error("key_redraw_scheduler: key row runs past the bottom screen edge");
  end
  if (KEY_W < 2) begin : g_bad_key_w
    $error("key_redraw_scheduler: KEY_W must leave room for a border column");
  end
  if (NUM_KEYS < 1) begin : g_bad_num_keys
    $error("key_redraw_scheduler: NUM_KEYS must be at least 1");
  end

  function automatic logic [7:0] pixel_x(input logic [IDX_W-1:0] k,
                                         input logic [PX_W-1:0]  p);
    return 8'(X0) + 8'(k) * 8'(KEY_W) + 8'(p);
  endfunction

  function automatic logic [6:0] pixel_y(input logic [PY_W-1:0] p);
    return 7'(Y0) + 7'(p);
  endfunction

  function automatic logic [2:0] pixel_colour(input logic [PX_W-1:0] p,
                                              input logic [2:0]      fill);
    return (p == PX_LAST) ? COL_BORDER : fill;
  endfunction

  state_t              state, state_n;
  logic [NUM_KEYS-1:0] key_q;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] chg;
  logic [NUM_KEYS-1:0] clr_mask;
  logic [IDX_W-1:0]    last_grant;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_vld;
  logic [2:0]          fill_col;
  logic [PX_W-1:0]     px;
  logic [PY_W-1:0]     py;
  logic                fill_last;
  logic                redraw_again;

  rr_picker #(
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_picker (
    .req        (pending),
    .last_grant (last_grant),
    .grant      (pick_idx),
    .vld        (pick_vld)
  );

  assign chg       = key_state ^ key_q;
  assign fill_last = (state == FILL) && (px == PX_LAST) && (py == PY_LAST);
  assign busy      = (state != IDLE);

  // A key that changed while its own fill was running keeps its pending
  // bit so it is redrawn later with the new colour.
  always_comb begin
    clr_mask = '0;
    if (fill_last && !redraw_again && !chg[idx]) begin
      clr_mask[idx] = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|pending) state_n = GRANT;
      GRANT:   state_n = pick_vld ? FILL : IDLE;
      FILL:    if (fill_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_q        <= '0;
      pending      <= '1;
      last_grant   <= IDX_LAST;
      init_done    <= 1'b0;
      redraw_again <= 1'b0;
      plot         <= 1'b0;
      x_out        <= '0;
      y_out        <= '0;
      VGA_COLOR    <= '0;
    end else begin
      key_q   <= key_state;
      // Set wins over clear: a change on the closing edge is kept.
      pending <= (pending & ~clr_mask) | chg;
      plot    <= 1'b0;

      if (state == IDLE && pending == '0) begin
        init_done <= 1'b1;
      end

      case (state)
        GRANT: begin
          if (pick_vld) begin
            idx          <= pick_idx;
            last_grant   <= pick_idx;
            // Colour is frozen here for the whole rectangle.
            fill_col     <= key_state[pick_idx] ? COL_PRESSED : COL_RELEASED;
            redraw_again <= 1'b0;
            px           <= '0;
            py           <= '0;
          end
        end
        FILL: begin
          plot      <= 1'b1;
          x_out     <= pixel_x(idx, px);
          y_out     <= pixel_y(py);
          VGA_COLOR <= pixel_colour(px, fill_col);
          if (chg[idx]) begin
            redraw_again <= 1'b1;
          end
          if (px == PX_LAST) begin
            px <= '0;
            if (py != PY_LAST) begin
              py <= py + 1'b1;
            end
          end else begin
            px <= px + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_redraw_scheduler.sv
module tb_key_redraw_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] key_state = 8'h00;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] VGA_COLOR;
  logic       plot;
  logic       busy;
  logic       init_done;

  int checks = 0;
  int failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  key_redraw_scheduler dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .key_state (key_state),
    .x_out     (x_out),
    .y_out     (y_out),
    .VGA_COLOR (VGA_COLOR),
    .plot      (plot),
    .busy      (busy),
    .init_done (init_done)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Counts plot=0 cycles until plot rises, bounded by budget.
  task automatic wait_fill_start(input int budget, output int zeros);
    zeros = 0;
    while (plot !== 1'b1 && zeros < budget) begin
      zeros++;
      tick();
    end
  endtask

  // Follows one fill from its first pixel; counts pixels that differ from
  // the geometry of the key implied by the first x. Optionally toggles keys
  // or pulses reset after a given pixel index.
  task automatic run_fill(input int toggle_at, input logic [7:0] tmask,
                          input int reset_at, output int key, output int npix,
                          output int bad, output logic [2:0] col0,
                          output logic [7:0] lx, output logic [6:0] ly,
                          output logic [2:0] lc);
    int k;
    int ex, ey;
    logic [2:0] ec;
    k    = 0;
    bad  = 0;
    key  = (x_out >= 8'd16) ? (int'(x_out) - 16) / 16 : -1;
    col0 = VGA_COLOR;
    lx = x_out; ly = y_out; lc = VGA_COLOR;
    while (plot === 1'b1 && k < 500) begin
      ex = 16 + key * 16 + (k % 16);
      ey = 89 + k / 16;
      ec = ((k % 16) == 15) ? 3'b000 : col0;
      if (k >= 400 || int'(x_out) != ex || int'(y_out) != ey || VGA_COLOR !== ec) bad++;
      lx = x_out; ly = y_out; lc = VGA_COLOR;
      if (k == toggle_at) key_state = key_state ^ tmask;
      k++;
      if (k - 1 == reset_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    npix = k;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_state = 8'h00;
    tick();
    tick();
    checks++; if (plot !== 1'b0) begin failures++; $display("FAIL reset_plot got=%b want=0", plot); end
    checks++; if (x_out !== 8'd0) begin failures++; $display("FAIL reset_x got=%0d want=0", x_out); end
    checks++; if (y_out !== 7'd0) begin failures++; $display("FAIL reset_y got=%0d want=0", y_out); end
    checks++; if (VGA_COLOR !== 3'b000) begin failures++; $display("FAIL reset_colour got=%b want=000", VGA_COLOR); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b want=0", init_done); end
  endtask

  task automatic test_initial_draw();
    int z, key, npix, bad;
    logic [2:0] c0, lc;
    logic [7:0] lx;
    logic [6:0] ly;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_fill_start(8, z);
      checks++; if (plot !== 1'b1) begin failures++; $display("FAIL init_start key%0d plot=%b want=1", i, plot); end
      if (i == 0) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL init_busy got=%b want=1", busy); end
      end else begin
        checks++; if (z != 2) begin failures++; $display("FAIL init_gap key%0d got=%0d want=2", i, z); end
      end
      run_fill(-1, 8'h00, -1, key, npix, bad, c0, lx, ly, lc);
      checks++; if (key != i) begin failures++; $display("FAIL init_order got=%0d want=%0d", key, i); end
      checks++; if (npix != 400) begin failures++; $display("FAIL init_len key%0d got=%0d want=400", i, npix); end
      checks++; if (bad != 0) begin failures++; $display("FAIL init_pixels key%0d bad=%0d want=0", i, bad); end
      checks++; if (c0 !== 3'b111) begin failures++; $display("FAIL init_colour key%0d got=%b want=111", i, c0); end
      if (i == 6) begin
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL init_done_early got=%b want=0", init_done); end
      end
    end
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_done_rise got=%b want=1", init_done); end
  endtask

  task automatic test_single_press();
    int key, npix, bad;
    logic [2:0] c0, lc;
    logic [7:0] lx;
    logic [6:0] ly;
    key_state[3] = 1'b1;
    tick(); tick(); tick();
    checks++; if (plot !== 1'b0) begin failures++; $display("FAIL press_latency_early plot=%b want=0", plot); end
    tick();
    checks++; if (plot !== 1'b1) begin failures++; $display("FAIL press_latency plot=%b want=1", plot); end
    checks++; if (x_out !== 8'd64 || y_out !== 7'd89) begin failures++; $display("FAIL press_first_xy got=(%0d,%0d) want=(64,89)", x_out, y_out); end
    checks++; if (VGA_COLOR !== 3'b100) begin failures++; $display("FAIL press_first_colour got=%b want=100", VGA_COLOR); end
    run_fill(-1, 8'h00, -1, key, npix, bad, c0, lx, ly, lc);
    checks++; if (npix != 400) begin failures++; $display("FAIL press_len got=%0d want=400", npix); end
    checks++; if (bad != 0) begin failures++; $display("FAIL press_pixels bad=%0d want=0", bad); end
    checks++; if (lx !== 8'd79 || ly !== 7'd113 || lc !== 3'b000) begin failures++; $display("FAIL press_last got=(%0d,%0d,%b) want=(79,113,000)", lx, ly, lc); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (plot !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL press_drained plot=%b busy=%b want=0,0", plot, busy); end
  endtask

  task automatic test_change_during_fill();
    int z, key, npix, bad;
    logic [2:0] c0, lc;
    logic [7:0] lx;
    logic [6:0] ly;
    key_state[3] = 1'b0;
    wait_fill_start(8, z);
    run_fill(-1, 8'h00, -1, key, npix, bad, c0, lx, ly, lc);
    checks++; if (key != 3 || c0 !== 3'b111) begin failures++; $display("FAIL release_fill got=key%0d/%b want=key3/111", key, c0); end
    key_state[3] = 1'b1;
    wait_fill_start(8, z);
    run_fill(150, 8'h08, -1, key, npix, bad, c0, lx, ly, lc);
    checks++; if (key != 3 || c0 !== 3'b100) begin failures++; $display("FAIL midfill_first got=key%0d/%b want=key3/100", key, c0); end
    checks++; if (bad != 0 || npix != 400) begin failures++; $display("FAIL midfill_stable bad=%0d len=%0d want=0/400", bad, npix); end
    wait_fill_start(8, z);
    checks++; if (z != 2) begin failures++; $display("FAIL midfill_gap got=%0d want=2", z); end
    run_fill(-1, 8'h00, -1, key, npix, bad, c0, lx, ly, lc);
    checks++; if (key != 3 || c0 !== 3'b111) begin failures++; $display("FAIL midfill_redraw got=key%0d/%b want=key3/111", key, c0); end
    checks++; if (bad != 0 || npix != 400) begin failures++; $display("FAIL midfill_redraw_px bad=%0d len=%0d want=0/400", bad, npix); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midfill_drained busy=%b want=0", busy); end
  endtask

  task automatic test_multi_change();
    int z, key, npix, bad;
    int exp_order[3] = '{5, 6, 1};
    logic [2:0] c0, lc;
    logic [7:0] lx;
    logic [6:0] ly;
    key_state = key_state ^ 8'b0110_0010;
    for (int j = 0; j < 3; j++) begin
      wait_fill_start(8, z);
      if (j > 0) begin
        checks++; if (z != 2) begin failures++; $display("FAIL multi_gap fill%0d got=%0d want=2", j, z); end
      end
      run_fill(-1, 8'h00, -1, key, npix, bad, c0, lx, ly, lc);
      checks++; if (key != exp_order[j]) begin failures++; $display("FAIL multi_order fill%0d got=%0d want=%0d", j, key, exp_order[j]); end
      checks++; if (c0 !== 3'b100 || bad != 0 || npix != 400) begin failures++; $display("FAIL multi_fill fill%0d colour=%b bad=%0d len=%0d want=100/0/400", j, c0, bad, npix); end
    end
  endtask

  task automatic test_reset_mid_fill();
    int z, key, npix, bad;
    logic [2:0] c0, lc, ec;
    logic [7:0] lx;
    logic [6:0] ly;
    key_state[0] = 1'b1;  // key_state now 0110_0011
    wait_fill_start(8, z);
    run_fill(-1, 8'h00, 200, key, npix, bad, c0, lx, ly, lc);
    checks++; if (key != 0 || npix != 201) begin failures++; $display("FAIL rst_mid_cut key=%0d len=%0d want=0/201", key, npix); end
    checks++; if (plot !== 1'b0 || init_done !== 1'b0) begin failures++; $display("FAIL rst_mid_outputs plot=%b init_done=%b want=0,0", plot, init_done); end
    for (int i = 0; i < 8; i++) begin
      wait_fill_start(8, z);
      run_fill(-1, 8'h00, -1, key, npix, bad, c0, lx, ly, lc);
      ec = (i == 0 || i == 1 || i == 5 || i == 6) ? 3'b100 : 3'b111;
      checks++; if (key != i) begin failures++; $display("FAIL rst_redraw_order got=%0d want=%0d", key, i); end
      checks++; if (c0 !== ec || bad != 0 || npix != 400) begin failures++; $display("FAIL rst_redraw key%0d colour=%b bad=%0d len=%0d want=%b/0/400", i, c0, bad, npix, ec); end
    end
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL rst_init_done got=%b want=1", init_done); end
  endtask

  task automatic test_stress();
    int zeros_run, ones_run, bad_area, bad_gap, bad_len, fills_before, key4_served, changed, k;
    logic prev_plot;
    zeros_run = 10; ones_run = 0; bad_area = 0; bad_gap = 0; bad_len = 0;
    fills_before = 0; key4_served = 0; changed = 0; prev_plot = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      if (c < 2000) key_state[2] = ~key_state[2];
      if (c == 50) begin key_state[4] = ~key_state[4]; changed = 1; end
      tick();
      if (plot === 1'b1) begin
        if (!prev_plot) begin
          if (zeros_run < 2) bad_gap++;
          k = (int'(x_out) - 16) / 16;
          if (changed == 1 && key4_served == 0) begin
            if (k == 4) key4_served = 1; else fills_before++;
          end
        end
        if (x_out < 8'd16 || x_out > 8'd143 || y_out < 7'd89 || y_out > 7'd113) bad_area++;
        ones_run++;
        zeros_run = 0;
      end else begin
        if (prev_plot && ones_run != 400) bad_len++;
        ones_run = 0;
        zeros_run++;
      end
      prev_plot = plot;
      if (c >= 2000 && zeros_run >= 4 && busy === 1'b0) break;
    end
    checks++; if (bad_area != 0) begin failures++; $display("FAIL stress_area got=%0d want=0", bad_area); end
    checks++; if (bad_gap != 0) begin failures++; $display("FAIL stress_gap got=%0d want=0", bad_gap); end
    checks++; if (bad_len != 0) begin failures++; $display("FAIL stress_len got=%0d want=0", bad_len); end
    checks++; if (key4_served != 1) begin failures++; $display("FAIL stress_key4_served got=%0d want=1", key4_served); end
    checks++; if (fills_before > 1) begin failures++; $display("FAIL stress_key4_wait got=%0d want<=1", fills_before); end
    checks++; if (busy !== 1'b0 || plot !== 1'b0) begin failures++; $display("FAIL stress_drain busy=%b plot=%b want=0,0", busy, plot); end
  endtask

  initial begin
    test_reset();
    test_initial_draw();
    test_single_press();
    test_change_during_fill();
    test_multi_change();
    test_reset_mid_fill();
    test_stress();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
